// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the fetch PC, handshakes with instruction memory, and absorbs one fetch while decode is stalled.
module fetch_stage #(
   parameter int                     PC_WIDTH    = 32,
   parameter int                     INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   Stall,
   input  logic                   Branch_Taken,
   input  logic [PC_WIDTH-1:0]    Branch_Address,
   output logic                   IMem_Req,
   output logic [PC_WIDTH-1:0]    IMem_Addr,
   input  logic                   IMem_Ready,
   input  logic [INSTR_WIDTH-1:0] IMem_Data,
   output logic [INSTR_WIDTH-1:0] Instruction,
   output logic [PC_WIDTH-1:0]    PC_Out,
   output logic                   Valid,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2,
      HELD  = 2'd3
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   state_t                   state_q, state_d;
   logic [PC_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0]      redirect_pc_q, redirect_pc_d;
   logic [INSTR_WIDTH-1:0]   buf_instr_q, buf_instr_d;
   logic [PC_WIDTH-1:0]      buf_pc_q, buf_pc_d;
   logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
   logic [PC_WIDTH-1:0]      pc_out_q, pc_out_d;
   logic                     valid_q, valid_d;

   logic                     load;
   logic [INSTR_WIDTH-1:0]   load_instr;
   logic [PC_WIDTH-1:0]      load_pc;
   logic [PC_WIDTH-1:0]      next_pc;

   assign next_pc = fetch_pc_q + PC_STEP;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      redirect_pc_d = redirect_pc_q;
      buf_instr_d   = buf_instr_q;
      buf_pc_d      = buf_pc_q;
      load          = 1'b0;
      load_instr    = IMem_Data;
      load_pc       = next_pc;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (Branch_Taken && IMem_Ready) begin
               fetch_pc_d = Branch_Address;
            end else if (Branch_Taken) begin
               // Outstanding request must complete at the old address first.
               redirect_pc_d = Branch_Address;
               state_d       = DROP;
            end else if (IMem_Ready && !Stall) begin
               load       = 1'b1;
               fetch_pc_d = next_pc;
            end else if (IMem_Ready) begin
               buf_instr_d = IMem_Data;
               buf_pc_d    = next_pc;
               fetch_pc_d  = next_pc;
               state_d     = HELD;
            end
         end
         DROP: begin
            if (IMem_Ready) begin
               fetch_pc_d = Branch_Taken ? Branch_Address : redirect_pc_q;
               state_d    = FETCH;
            end else if (Branch_Taken) begin
               redirect_pc_d = Branch_Address;
            end
         end
         HELD: begin
            if (Branch_Taken) begin
               fetch_pc_d = Branch_Address;
               state_d    = FETCH;
            end else if (!Stall) begin
               load       = 1'b1;
               load_instr = buf_instr_q;
               load_pc    = buf_pc_q;
               state_d    = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // IF/ID: flush beats stall, stall beats load, otherwise a bubble.
   always_comb begin
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      if (Branch_Taken) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (Stall) begin
         instr_d = instr_q;
      end else if (load) begin
         instr_d  = load_instr;
         pc_out_d = load_pc;
         valid_d  = 1'b1;
      end else begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RESET_PC;
         redirect_pc_q <= '0;
         buf_instr_q   <= NOP_INSTR;
         buf_pc_q      <= '0;
         instr_q       <= NOP_INSTR;
         pc_out_q      <= '0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         redirect_pc_q <= redirect_pc_d;
         buf_instr_q   <= buf_instr_d;
         buf_pc_q      <= buf_pc_d;
         instr_q       <= instr_d;
         pc_out_q      <= pc_out_d;
         valid_q       <= valid_d;
      end
   end

   assign IMem_Req    = (state_q == FETCH) || (state_q == DROP);
   assign IMem_Addr   = fetch_pc_q;
   assign Instruction = instr_q;
   assign PC_Out      = pc_out_q;
   assign Valid       = valid_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns 0xC0DE0000 | address, Ready is driven per cycle.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        Stall;
   logic        Branch_Taken;
   logic [31:0] Branch_Address;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_Ready;
   logic [31:0] IMem_Data;
   logic [31:0] Instruction;
   logic [31:0] PC_Out;
   logic        Valid;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_DROP = 2'd2, S_HELD = 2'd3;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .Stall          (Stall),
      .Branch_Taken   (Branch_Taken),
      .Branch_Address (Branch_Address),
      .IMem_Req       (IMem_Req),
      .IMem_Addr      (IMem_Addr),
      .IMem_Ready     (IMem_Ready),
      .IMem_Data      (IMem_Data),
      .Instruction    (Instruction),
      .PC_Out         (PC_Out),
      .Valid          (Valid),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign IMem_Data = 32'hC0DE_0000 | IMem_Addr;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      Stall          = 1'b0;
      Branch_Taken   = 1'b0;
      Branch_Address = '0;
      IMem_Ready     = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      #1;
      checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp %h", Instruction, 32'h0); end
      checks++; if (PC_Out !== 32'h0) begin errors++; $display("FAIL rst_pc_out: got %h exp %h", PC_Out, 32'h0); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", Valid); end
      checks++; if (IMem_Req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", IMem_Req); end
      checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, S_IDLE); end
      tick();
   endtask

   task automatic test_zero_wait();
      do_reset();
      IMem_Ready = 1'b1;
      tick();
      checks++; if (IMem_Req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b exp 1", IMem_Req); end
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL zw_addr0: got %h exp %h", IMem_Addr, 32'h0); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0000) begin errors++; $display("FAIL zw_instr0: got %h exp %h", Instruction, 32'hC0DE_0000); end
      checks++; if (PC_Out !== 32'h4) begin errors++; $display("FAIL zw_pc0: got %h exp %h", PC_Out, 32'h4); end
      checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL zw_valid0: got %b exp 1", Valid); end
      checks++; if (IMem_Addr !== 32'h4) begin errors++; $display("FAIL zw_addr4: got %h exp %h", IMem_Addr, 32'h4); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0004) begin errors++; $display("FAIL zw_instr4: got %h exp %h", Instruction, 32'hC0DE_0004); end
      checks++; if (PC_Out !== 32'h8) begin errors++; $display("FAIL zw_pc4: got %h exp %h", PC_Out, 32'h8); end
      checks++; if (IMem_Addr !== 32'h8) begin errors++; $display("FAIL zw_addr8: got %h exp %h", IMem_Addr, 32'h8); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0008) begin errors++; $display("FAIL zw_instr8: got %h exp %h", Instruction, 32'hC0DE_0008); end
      checks++; if (PC_Out !== 32'hC) begin errors++; $display("FAIL zw_pc8: got %h exp %h", PC_Out, 32'hC); end
      checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL zw_valid8: got %b exp 1", Valid); end
   endtask

   task automatic test_latency2();
      do_reset();
      tick();
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL lat_addr_c1: got %h exp %h", IMem_Addr, 32'h0); end
      tick();
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL lat_addr_c2: got %h exp %h", IMem_Addr, 32'h0); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL lat_valid_wait: got %b exp 0", Valid); end
      IMem_Ready = 1'b1;
      tick();
      IMem_Ready = 1'b0;
      checks++; if (Instruction !== 32'hC0DE_0000) begin errors++; $display("FAIL lat_instr0: got %h exp %h", Instruction, 32'hC0DE_0000); end
      checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL lat_valid_pulse: got %b exp 1", Valid); end
      checks++; if (IMem_Addr !== 32'h4) begin errors++; $display("FAIL lat_addr4: got %h exp %h", IMem_Addr, 32'h4); end
      tick();
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL lat_bubble_valid: got %b exp 0", Valid); end
      checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL lat_bubble_instr: got %h exp %h", Instruction, 32'h0); end
      checks++; if (PC_Out !== 32'h4) begin errors++; $display("FAIL lat_bubble_pc: got %h exp %h", PC_Out, 32'h4); end
      IMem_Ready = 1'b1;
      tick();
      checks++; if (Instruction !== 32'hC0DE_0004) begin errors++; $display("FAIL lat_instr4: got %h exp %h", Instruction, 32'hC0DE_0004); end
      checks++; if (PC_Out !== 32'h8) begin errors++; $display("FAIL lat_pc4: got %h exp %h", PC_Out, 32'h8); end
   endtask

   task automatic test_stall_held();
      do_reset();
      IMem_Ready = 1'b1;
      tick();
      tick();
      tick();
      Stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (dbg_state !== S_HELD) begin errors++; $display("FAIL st_state_%0d: got %0d exp %0d", c, dbg_state, S_HELD); end
         checks++; if (IMem_Req !== 1'b0) begin errors++; $display("FAIL st_req_%0d: got %b exp 0", c, IMem_Req); end
         checks++; if (Instruction !== 32'hC0DE_0004) begin errors++; $display("FAIL st_instr_%0d: got %h exp %h", c, Instruction, 32'hC0DE_0004); end
         checks++; if (PC_Out !== 32'h8) begin errors++; $display("FAIL st_pc_%0d: got %h exp %h", c, PC_Out, 32'h8); end
      end
      Stall = 1'b0;
      tick();
      checks++; if (Instruction !== 32'hC0DE_0008) begin errors++; $display("FAIL st_buf_instr: got %h exp %h", Instruction, 32'hC0DE_0008); end
      checks++; if (PC_Out !== 32'hC) begin errors++; $display("FAIL st_buf_pc: got %h exp %h", PC_Out, 32'hC); end
      checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL st_buf_valid: got %b exp 1", Valid); end
      checks++; if (IMem_Addr !== 32'hC) begin errors++; $display("FAIL st_resume_addr: got %h exp %h", IMem_Addr, 32'hC); end
      checks++; if (IMem_Req !== 1'b1) begin errors++; $display("FAIL st_resume_req: got %b exp 1", IMem_Req); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_000C) begin errors++; $display("FAIL st_next_instr: got %h exp %h", Instruction, 32'hC0DE_000C); end
      checks++; if (PC_Out !== 32'h10) begin errors++; $display("FAIL st_next_pc: got %h exp %h", PC_Out, 32'h10); end
   endtask

   task automatic test_branch_pending();
      do_reset();
      tick();
      Branch_Taken   = 1'b1;
      Branch_Address = 32'h40;
      tick();
      Branch_Taken = 1'b0;
      checks++; if (dbg_state !== S_DROP) begin errors++; $display("FAIL bp_state: got %0d exp %0d", dbg_state, S_DROP); end
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL bp_addr_hold1: got %h exp %h", IMem_Addr, 32'h0); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bp_valid1: got %b exp 0", Valid); end
      tick();
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL bp_addr_hold2: got %h exp %h", IMem_Addr, 32'h0); end
      checks++; if (IMem_Req !== 1'b1) begin errors++; $display("FAIL bp_req: got %b exp 1", IMem_Req); end
      IMem_Ready = 1'b1;
      tick();
      checks++; if (IMem_Addr !== 32'h40) begin errors++; $display("FAIL bp_addr_target: got %h exp %h", IMem_Addr, 32'h40); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bp_valid_discard: got %b exp 0", Valid); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0040) begin errors++; $display("FAIL bp_instr: got %h exp %h", Instruction, 32'hC0DE_0040); end
      checks++; if (PC_Out !== 32'h44) begin errors++; $display("FAIL bp_pc: got %h exp %h", PC_Out, 32'h44); end
   endtask

   task automatic test_branch_zero_wait();
      do_reset();
      IMem_Ready = 1'b1;
      tick();
      tick();
      Branch_Taken   = 1'b1;
      Branch_Address = 32'h100;
      tick();
      Branch_Taken = 1'b0;
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bz_flush_valid: got %b exp 0", Valid); end
      checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL bz_flush_instr: got %h exp %h", Instruction, 32'h0); end
      checks++; if (PC_Out !== 32'h4) begin errors++; $display("FAIL bz_flush_pc: got %h exp %h", PC_Out, 32'h4); end
      checks++; if (IMem_Addr !== 32'h100) begin errors++; $display("FAIL bz_addr: got %h exp %h", IMem_Addr, 32'h100); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0100) begin errors++; $display("FAIL bz_instr: got %h exp %h", Instruction, 32'hC0DE_0100); end
      checks++; if (PC_Out !== 32'h104) begin errors++; $display("FAIL bz_pc: got %h exp %h", PC_Out, 32'h104); end
   endtask

   task automatic test_branch_stall_held();
      do_reset();
      IMem_Ready = 1'b1;
      tick();
      tick();
      Stall = 1'b1;
      tick();
      checks++; if (dbg_state !== S_HELD) begin errors++; $display("FAIL bs_state_held: got %0d exp %0d", dbg_state, S_HELD); end
      Branch_Taken   = 1'b1;
      Branch_Address = 32'h80;
      tick();
      Branch_Taken = 1'b0;
      Stall        = 1'b0;
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL bs_flush_valid: got %b exp 0", Valid); end
      checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL bs_flush_instr: got %h exp %h", Instruction, 32'h0); end
      checks++; if (dbg_state !== S_FETCH) begin errors++; $display("FAIL bs_state_fetch: got %0d exp %0d", dbg_state, S_FETCH); end
      checks++; if (IMem_Addr !== 32'h80) begin errors++; $display("FAIL bs_addr: got %h exp %h", IMem_Addr, 32'h80); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0080) begin errors++; $display("FAIL bs_instr: got %h exp %h", Instruction, 32'hC0DE_0080); end
      checks++; if (PC_Out !== 32'h84) begin errors++; $display("FAIL bs_pc: got %h exp %h", PC_Out, 32'h84); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      IMem_Ready = 1'b1;
      tick();
      Branch_Taken   = 1'b1;
      Branch_Address = 32'h18;
      tick();
      Branch_Taken = 1'b0;
      tick();
      checks++; if (IMem_Addr !== 32'h1C) begin errors++; $display("FAIL rm_addr_pre: got %h exp %h", IMem_Addr, 32'h1C); end
      checks++; if (Valid !== 1'b1) begin errors++; $display("FAIL rm_valid_pre: got %b exp 1", Valid); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (IMem_Req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", IMem_Req); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b exp 0", Valid); end
      checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL rm_instr: got %h exp %h", Instruction, 32'h0); end
      checks++; if (PC_Out !== 32'h0) begin errors++; $display("FAIL rm_pc: got %h exp %h", PC_Out, 32'h0); end
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h exp %h", IMem_Addr, 32'h0); end
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++; if (IMem_Addr !== 32'h0) begin errors++; $display("FAIL rm_restart_addr: got %h exp %h", IMem_Addr, 32'h0); end
      tick();
      checks++; if (Instruction !== 32'hC0DE_0000) begin errors++; $display("FAIL rm_restart_instr: got %h exp %h", Instruction, 32'hC0DE_0000); end
      checks++; if (PC_Out !== 32'h4) begin errors++; $display("FAIL rm_restart_pc: got %h exp %h", PC_Out, 32'h4); end
   endtask

   initial begin
      rst            = 1'b0;
      Stall          = 1'b0;
      Branch_Taken   = 1'b0;
      Branch_Address = '0;
      IMem_Ready     = 1'b0;
      test_reset();
      test_zero_wait();
      test_latency2();
      test_stall_held();
      test_branch_pending();
      test_branch_zero_wait();
      test_branch_stall_held();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline. It owns the fetch PC and runs a request/ready handshake to instruction memory. It registers each fetched instruction into IF/ID for the decode stage. It is the direct consumer of the hazard unit's Stall: it holds IF/ID and buffers one in-flight fetch while stalled, and flushes or redirects on a taken branch from EXE.

## Interface
- PC_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
- NOP_INSTR, 0, encoding loaded into IF/ID on bubble or flush.

One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit stall; hold IF/ID.
- Branch_Taken  in  1  EXE-resolved taken branch or jump.
- Branch_Address  in  PC_WIDTH  redirect target; valid when Branch_Taken=1.
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  PC_WIDTH  fetch address; stable while IMem_Req=1 and IMem_Ready=0.
- IMem_Ready  in  1  memory returns IMem_Data this cycle; accepted only when IMem_Req=1.
- IMem_Data  in  INSTR_WIDTH  fetched instruction.
- Instruction  out  INSTR_WIDTH  IF/ID instruction.
- PC_Out  out  PC_WIDTH  IF/ID PC, which is the fetch address + 4.
- Valid  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - Fetch_PC, the address of the current or next fetch.
  - Redirect_PC.
  - Buf_Instr and Buf_PC, a one-entry skid buffer.
  - state, one of IDLE, FETCH, DROP, HELD.
  - the IF/ID registers Instruction, PC_Out and Valid.
- All PC arithmetic is modulo 2^PC_WIDTH; the increment is always +4.
- IMem_Req=1 in FETCH and DROP only, and IMem_Addr=Fetch_PC.
- IDLE: entered on reset. Next state is FETCH unconditionally.
- FETCH, in priority order:
  - Branch_Taken & IMem_Ready: discard the data, Fetch_PC<=Branch_Address, stay in FETCH.
  - Branch_Taken & !IMem_Ready: Redirect_PC<=Branch_Address, go to DROP. The address must stay stable until the outstanding request completes.
  - IMem_Ready & !Stall: load IF/ID with IMem_Data and Fetch_PC+4, set Valid=1, Fetch_PC<=Fetch_PC+4.
  - IMem_Ready & Stall: Buf_Instr<=IMem_Data, Buf_PC<=Fetch_PC+4, Fetch_PC<=Fetch_PC+4, go to HELD.
  - Otherwise hold.
- DROP:
  - IMem_Ready: discard the data. Fetch_PC<=Branch_Address if Branch_Taken, else Redirect_PC. Go to FETCH.
  - Branch_Taken & !IMem_Ready: Redirect_PC<=Branch_Address; the latest branch wins.
- HELD:
  - Branch_Taken: discard the buffer, Fetch_PC<=Branch_Address, go to FETCH.
  - !Stall: load IF/ID from the buffer with Valid=1, go to FETCH.
  - Stall: hold.
- IF/ID update, in priority order:
  1. Branch_Taken flushes: Instruction=NOP_INSTR, Valid=0, PC_Out unchanged. This overrides Stall.
  2. Stall holds all IF/ID registers.
  3. Load from the buffer or memory as above.
  4. Otherwise insert a bubble: Instruction=NOP_INSTR, Valid=0, PC_Out unchanged.

## Timing
- Reset (asynchronous, rst=0) sets:
  - state=IDLE, Fetch_PC=RESET_PC, Redirect_PC=0.
  - Buf_Instr=NOP_INSTR, Buf_PC=0.
  - Instruction=NOP_INSTR, PC_Out=0, Valid=0.
  - IMem_Req=0.
- The first request is raised in the cycle after the first rising edge following rst release.
- Fetch-to-IF/ID latency: data accepted in cycle N appears on Instruction/PC_Out/Valid after the edge ending cycle N.
- Zero-wait memory (IMem_Ready tied high) sustains one instruction per cycle with no bubbles.
- While in HELD, no request is issued; at most one fetched instruction is ever buffered.
- A branch costs at least one bubble. With zero-wait memory, the target instruction reaches IF/ID two edges after the Branch_Taken cycle.
- rst asserted mid-request abandons the request immediately; the memory is reset by the same rst.
- IMem_Ready while IMem_Req=0 is ignored.

## Test plan
- Reset release with RESET_PC=0 and zero-wait memory: requests go to addresses 0, 4, 8. Instruction holds the data for address 0 with PC_Out=4 and Valid=1 two edges after release, then advances one instruction per cycle.
- 2-cycle memory latency: IMem_Addr=0 is held for 2 cycles. Valid pulses 1 for one cycle, then is 0 until the next Ready.
- Stall=1 for 3 cycles while data for address 8 returns: state becomes HELD, IMem_Req=0, and IF/ID is unchanged. When Stall drops, Instruction takes the data for address 8 with PC_Out=12, then fetching resumes at 12.
- Branch_Taken to 0x40 during a pending request with no Ready: IMem_Addr stays at the old value until Ready. That data is discarded, the next request goes to 0x40, and Valid=0 throughout.
- Branch_Taken and Stall both asserted, in HELD: IF/ID is flushed (Valid=0, NOP_INSTR), the buffer is discarded, and the next request goes to Branch_Address.
- rst asserted mid-fetch with Fetch_PC=0x1C: all outputs take their reset values immediately. Fetching restarts at RESET_PC after release.
